// File: rtl/mem_pkg.sv
`default_nettype none
// ============================================================================
// Module  : mem_pkg
// Purpose : Shared funct3 codes, FSM state type and wait-counter width for
//           the data memory responder.
// Rev     : 1.0  initial release
// ============================================================================
package mem_pkg;

  localparam logic [2:0] F3_B  = 3'b000;
  localparam logic [2:0] F3_H  = 3'b001;
  localparam logic [2:0] F3_W  = 3'b010;
  localparam logic [2:0] F3_BU = 3'b100;
  localparam logic [2:0] F3_HU = 3'b101;

  localparam int WAIT_CNT_W = 4;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_WAIT = 2'd1,
    ST_RESP = 2'd2
  } state_t;

  // Unsigned sizes only make sense for loads.
  function automatic logic f3_legal(input logic [2:0] f3, input logic we);
    case (f3)
      F3_B, F3_H, F3_W: return 1'b1;
      F3_BU, F3_HU:     return !we;
      default:          return 1'b0;
    endcase
  endfunction

endpackage
`default_nettype wire

// File: rtl/mem_lane_align.sv
`default_nettype none
// ============================================================================
// Module  : mem_lane_align
// Purpose : Byte-lane steering for stores and extension of loaded data.
// Rev     : 1.0  initial release
// ============================================================================
module mem_lane_align
  import mem_pkg::*;
(
  input  logic [2:0]  funct3,
  input  logic [1:0]  addr_lo,
  input  logic [31:0] wdata,
  input  logic [31:0] rword,
  output logic [3:0]  be,
  output logic [31:0] wword,
  output logic [31:0] rext,
  output logic        misalign
);

  logic [7:0]  w_byte;
  logic [15:0] w_half;

  always_comb begin
    w_byte   = rword[{addr_lo, 3'b000} +: 8];
    w_half   = addr_lo[1] ? rword[31:16] : rword[15:0];
    be       = 4'b0000;
    wword    = 32'h0;
    rext     = 32'h0;
    misalign = 1'b0;
    case (funct3)
      F3_B, F3_BU: begin
        be    = 4'b0001 << addr_lo;
        wword = {4{wdata[7:0]}};
        rext  = (funct3 == F3_B) ? {{24{w_byte[7]}}, w_byte} : {24'h0, w_byte};
      end
      F3_H, F3_HU: begin
        misalign = addr_lo[0];
        be       = addr_lo[1] ? 4'b1100 : 4'b0011;
        wword    = {2{wdata[15:0]}};
        rext     = (funct3 == F3_H) ? {{16{w_half[15]}}, w_half} : {16'h0, w_half};
      end
      F3_W: begin
        misalign = |addr_lo;
        be       = 4'b1111;
        wword    = wdata;
        rext     = rword;
      end
      default: ;
    endcase
  end

endmodule
`default_nettype wire

// File: rtl/data_mem_responder.sv
`default_nettype none
// ============================================================================
// Module  : data_mem_responder
// Purpose : Single-outstanding RV32I load/store responder over an internal
//           word array, with programmable wait states.
// Rev     : 1.0  initial release
// ============================================================================
module data_mem_responder
  import mem_pkg::*;
#(
  parameter int DEPTH_WORDS = 64,
  parameter int WAIT_CYCLES = 2
)(
  input  logic        clk,
  input  logic        reset,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic        req_we,
  input  logic [31:0] req_addr,
  input  logic [31:0] req_wdata,
  input  logic [2:0]  req_funct3,
  output logic        rsp_valid,
  input  logic        rsp_ready,
  output logic [31:0] rsp_rdata,
  output logic        rsp_err
);

  localparam int IDX_W = (DEPTH_WORDS > 1) ? $clog2(DEPTH_WORDS) : 1;
  localparam logic [29:0]           c_depth = 30'(DEPTH_WORDS);
  localparam logic [WAIT_CNT_W-1:0] c_wait  = WAIT_CNT_W'(WAIT_CYCLES);

  state_t                r_state, w_state_nx;
  logic [WAIT_CNT_W-1:0] r_cnt, w_cnt_nx;
  logic                  w_enter_resp;

  logic                  r_we;
  logic [31:0]           r_addr, r_wdata;
  logic [2:0]            r_funct3;
  logic [31:0]           r_rdata;
  logic                  r_err;

  logic [31:0]           r_mem [DEPTH_WORDS];

  // With zero wait states the access completes on the accept edge, so the
  // operation is taken straight from the request port while idle.
  logic                  w_in_idle;
  logic                  w_op_we;
  logic [31:0]           w_op_addr, w_op_wdata;
  logic [2:0]            w_op_f3;
  logic [IDX_W-1:0]      w_idx;
  logic                  w_oor, w_err, w_misalign, w_mem_we;
  logic [31:0]           w_rword, w_wword, w_rext;
  logic [3:0]            w_be;

  assign w_in_idle  = (r_state == ST_IDLE);
  assign w_op_we    = w_in_idle ? req_we     : r_we;
  assign w_op_addr  = w_in_idle ? req_addr   : r_addr;
  assign w_op_wdata = w_in_idle ? req_wdata  : r_wdata;
  assign w_op_f3    = w_in_idle ? req_funct3 : r_funct3;

  assign w_idx    = w_op_addr[IDX_W+1:2];
  assign w_oor    = (w_op_addr[31:2] >= c_depth);
  assign w_rword  = w_oor ? 32'h0 : r_mem[w_idx];
  assign w_err    = !f3_legal(w_op_f3, w_op_we) || w_misalign || w_oor;
  assign w_mem_we = w_enter_resp && w_op_we && !w_err;

  mem_lane_align u_align (
    .funct3   (w_op_f3),
    .addr_lo  (w_op_addr[1:0]),
    .wdata    (w_op_wdata),
    .rword    (w_rword),
    .be       (w_be),
    .wword    (w_wword),
    .rext     (w_rext),
    .misalign (w_misalign)
  );

  always_comb begin
    w_state_nx   = r_state;
    w_cnt_nx     = r_cnt;
    w_enter_resp = 1'b0;
    case (r_state)
      ST_IDLE: begin
        if (req_valid) begin
          w_cnt_nx = c_wait;
          if (WAIT_CYCLES == 0) begin
            w_state_nx   = ST_RESP;
            w_enter_resp = 1'b1;
          end else begin
            w_state_nx = ST_WAIT;
          end
        end
      end
      ST_WAIT: begin
        w_cnt_nx = r_cnt - 1'b1;
        if (r_cnt <= 1) begin
          w_cnt_nx     = '0;
          w_state_nx   = ST_RESP;
          w_enter_resp = 1'b1;
        end
      end
      ST_RESP: begin
        if (rsp_ready) w_state_nx = ST_IDLE;
      end
      default: w_state_nx = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_state <= ST_IDLE;
      r_cnt   <= '0;
    end else begin
      r_state <= w_state_nx;
      r_cnt   <= w_cnt_nx;
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_we     <= 1'b0;
      r_addr   <= 32'h0;
      r_wdata  <= 32'h0;
      r_funct3 <= 3'b000;
      r_rdata  <= 32'h0;
      r_err    <= 1'b0;
    end else begin
      if (w_in_idle && req_valid) begin
        r_we     <= req_we;
        r_addr   <= req_addr;
        r_wdata  <= req_wdata;
        r_funct3 <= req_funct3;
      end
      if (w_enter_resp) begin
        r_rdata <= (w_err || w_op_we) ? 32'h0 : w_rext;
        r_err   <= w_err;
      end
    end
  end

  // Storage is deliberately left unreset.
  always_ff @(posedge clk) begin
    if (w_mem_we) begin
      for (int i = 0; i < 4; i++) begin
        if (w_be[i]) r_mem[w_idx][8*i +: 8] <= w_wword[8*i +: 8];
      end
    end
  end

  assign req_ready = w_in_idle;
  assign rsp_valid = (r_state == ST_RESP);
  assign rsp_rdata = r_rdata;
  assign rsp_err   = r_err;

endmodule
`default_nettype wire

// File: tb/tb_data_mem_responder.sv
`default_nettype none
// ============================================================================
// Module  : tb_data_mem_responder
// Purpose : Directed vector bench for data_mem_responder (64 words, 2 waits).
// Rev     : 1.0  initial release
// ============================================================================
module tb_data_mem_responder;

  logic        clk = 1'b0;
  logic        reset = 1'b0;
  logic        req_valid = 1'b0;
  logic        req_ready;
  logic        req_we = 1'b0;
  logic [31:0] req_addr = 32'h0;
  logic [31:0] req_wdata = 32'h0;
  logic [2:0]  req_funct3 = 3'b000;
  logic        rsp_valid;
  logic        rsp_ready = 1'b1;
  logic [31:0] rsp_rdata;
  logic        rsp_err;

  int n_checks = 0;
  int n_fail   = 0;

  data_mem_responder #(.DEPTH_WORDS(64), .WAIT_CYCLES(2)) dut (
    .clk        (clk),
    .reset      (reset),
    .req_valid  (req_valid),
    .req_ready  (req_ready),
    .req_we     (req_we),
    .req_addr   (req_addr),
    .req_wdata  (req_wdata),
    .req_funct3 (req_funct3),
    .rsp_valid  (rsp_valid),
    .rsp_ready  (rsp_ready),
    .rsp_rdata  (rsp_rdata),
    .rsp_err    (rsp_err)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic        we;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [2:0]  f3;
    logic [31:0] exp_rdata;
    logic        exp_err;
  } vec_t;

  localparam int NV = 24;
  vec_t vecs [NV];

  task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%08h, expected 0x%08h", nm, act, exp);
    end
  endtask

  // Issues one request and leaves the bench at the negedge where the
  // response is first visible (rsp_ready is driven low by the caller to stall).
  task automatic issue(input vec_t v, input string nm, output int lat);
    int spin;
    spin = 0;
    while (!req_ready && spin < 20) begin
      @(negedge clk);
      spin++;
    end
    check({nm, "_req_ready"}, {31'h0, req_ready}, 32'h1);
    req_we     = v.we;
    req_addr   = v.addr;
    req_wdata  = v.wdata;
    req_funct3 = v.f3;
    req_valid  = 1'b1;
    @(posedge clk);
    lat = 1;
    @(negedge clk);
    req_valid = 1'b0;
    while (!rsp_valid && lat < 20) begin
      @(posedge clk);
      lat++;
      @(negedge clk);
    end
  endtask

  task automatic access(input vec_t v, input string nm);
    int lat;
    issue(v, nm, lat);
    check({nm, "_latency"}, 32'(lat), 32'd3);
    check({nm, "_rdata"}, rsp_rdata, v.exp_rdata);
    check({nm, "_err"}, {31'h0, rsp_err}, {31'h0, v.exp_err});
    @(negedge clk);
  endtask

  initial begin
    vec_t v;
    int   lat;
    logic [31:0] held_rdata;
    logic        held_err;

    //           we    addr           wdata          f3      exp_rdata      err
    vecs[0]  = '{1'b1, 32'h0000_0010, 32'h1234_5678, 3'b010, 32'h0000_0000, 1'b0};
    vecs[1]  = '{1'b0, 32'h0000_0010, 32'h0,         3'b010, 32'h1234_5678, 1'b0};
    vecs[2]  = '{1'b1, 32'h0000_0014, 32'h0,         3'b010, 32'h0000_0000, 1'b0};
    vecs[3]  = '{1'b1, 32'h0000_0015, 32'h0000_00AB, 3'b000, 32'h0000_0000, 1'b0};
    vecs[4]  = '{1'b0, 32'h0000_0014, 32'h0,         3'b010, 32'h0000_AB00, 1'b0};
    vecs[5]  = '{1'b0, 32'h0000_0015, 32'h0,         3'b000, 32'hFFFF_FFAB, 1'b0};
    vecs[6]  = '{1'b0, 32'h0000_0015, 32'h0,         3'b100, 32'h0000_00AB, 1'b0};
    vecs[7]  = '{1'b0, 32'h0000_0012, 32'h0,         3'b010, 32'h0000_0000, 1'b1};
    vecs[8]  = '{1'b1, 32'h0000_0013, 32'h0000_BEEF, 3'b001, 32'h0000_0000, 1'b1};
    vecs[9]  = '{1'b0, 32'h0000_0010, 32'h0,         3'b010, 32'h1234_5678, 1'b0};
    vecs[10] = '{1'b1, 32'h0000_0016, 32'h5555_BEEF, 3'b001, 32'h0000_0000, 1'b0};
    vecs[11] = '{1'b0, 32'h0000_0014, 32'h0,         3'b010, 32'hBEEF_AB00, 1'b0};
    vecs[12] = '{1'b0, 32'h0000_0016, 32'h0,         3'b001, 32'hFFFF_BEEF, 1'b0};
    vecs[13] = '{1'b0, 32'h0000_0016, 32'h0,         3'b101, 32'h0000_BEEF, 1'b0};
    vecs[14] = '{1'b0, 32'h0000_0014, 32'h0,         3'b001, 32'hFFFF_AB00, 1'b0};
    vecs[15] = '{1'b0, 32'h0000_0012, 32'h0,         3'b000, 32'h0000_0034, 1'b0};
    vecs[16] = '{1'b0, 32'h0000_0013, 32'h0,         3'b100, 32'h0000_0012, 1'b0};
    vecs[17] = '{1'b1, 32'h0000_0010, 32'h0000_00FF, 3'b100, 32'h0000_0000, 1'b1};
    vecs[18] = '{1'b0, 32'h0000_0100, 32'h0,         3'b011, 32'h0000_0000, 1'b1};
    vecs[19] = '{1'b1, 32'h0000_00FC, 32'hCAFE_F00D, 3'b010, 32'h0000_0000, 1'b0};
    vecs[20] = '{1'b0, 32'h0000_00FE, 32'h0,         3'b101, 32'h0000_CAFE, 1'b0};
    vecs[21] = '{1'b0, 32'h8000_0010, 32'h0,         3'b010, 32'h0000_0000, 1'b1};
    vecs[22] = '{1'b0, 32'h0000_0011, 32'h0,         3'b101, 32'h0000_0000, 1'b1};
    vecs[23] = '{1'b0, 32'h0000_0010, 32'h0,         3'b010, 32'h1234_5678, 1'b0};

    #1;
    check("rst_rsp_valid", {31'h0, rsp_valid}, 32'h0);
    check("rst_rsp_rdata", rsp_rdata, 32'h0);
    check("rst_rsp_err",   {31'h0, rsp_err}, 32'h0);
    repeat (2) @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
    check("rst_req_ready", {31'h0, req_ready}, 32'h1);

    for (int i = 0; i < NV; i++) begin
      access(vecs[i], $sformatf("v%0d", i));
    end

    // Response held under back-pressure.
    v = '{1'b0, 32'h0000_0010, 32'h0, 3'b010, 32'h1234_5678, 1'b0};
    rsp_ready = 1'b0;
    issue(v, "stall", lat);
    check("stall_latency", 32'(lat), 32'd3);
    held_rdata = rsp_rdata;
    held_err   = rsp_err;
    check("stall_rdata", held_rdata, 32'h1234_5678);
    for (int k = 0; k < 5; k++) begin
      @(negedge clk);
      check($sformatf("stall%0d_valid", k), {31'h0, rsp_valid}, 32'h1);
      check($sformatf("stall%0d_rdata", k), rsp_rdata, held_rdata);
      check($sformatf("stall%0d_err", k), {31'h0, rsp_err}, {31'h0, held_err});
      check($sformatf("stall%0d_req_ready", k), {31'h0, req_ready}, 32'h0);
    end
    rsp_ready = 1'b1;
    @(negedge clk);
    check("stall_release_valid", {31'h0, rsp_valid}, 32'h0);
    check("stall_release_ready", {31'h0, req_ready}, 32'h1);

    // Reset in WAIT aborts the pending store.
    access('{1'b1, 32'h0000_0020, 32'h1122_3344, 3'b010, 32'h0, 1'b0}, "pre20");
    req_we = 1'b1; req_addr = 32'h20; req_wdata = 32'hDEAD_BEEF; req_funct3 = 3'b010;
    req_valid = 1'b1;
    @(posedge clk);
    @(negedge clk);
    req_valid = 1'b0;
    check("abort_in_wait", {31'h0, rsp_valid}, 32'h0);
    reset = 1'b0;
    #1;
    check("abort_rsp_valid", {31'h0, rsp_valid}, 32'h0);
    check("abort_rsp_rdata", rsp_rdata, 32'h0);
    check("abort_rsp_err",   {31'h0, rsp_err}, 32'h0);
    check("abort_req_ready", {31'h0, req_ready}, 32'h1);
    repeat (2) @(posedge clk);
    @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
    access('{1'b0, 32'h0000_0020, 32'h0, 3'b010, 32'h1122_3344, 1'b0}, "post20");

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
`default_nettype wire
